apb_master_bridge: RTL and testbench
====================================

// Module: apb_master_bridge
// PURPOSE
//  APB requester for the SPI controller's register block: converts single-beat commands (valid/ready) into
//  APB SETUP/ACCESS transfers, honours PREADY wait states, returns read data and PSLVERR as one response.
//  Sits between the system command source (CPU stub / sequencer) and the APB slave interface.
// PARAMETERS
//  ADDR_WIDTH      3   PADDR / cmd_addr width
//  DATA_WIDTH      8   PWDATA / PRDATA / cmd_wdata / rsp_rdata width
//  TIMEOUT_CYCLES  16  max ACCESS wait cycles before abort (only with APB_MASTER_TIMEOUT_EN)
// PORTS
//  PCLK        in   1           APB clock; all logic rising-edge
//  PRESETn     in   1           async active-low reset
//  cmd_valid   in   1           command present
//  cmd_ready   out  1           command accepted when cmd_valid & cmd_ready
//  cmd_write   in   1           1 = write, 0 = read
//  cmd_addr    in   ADDR_WIDTH  register address
//  cmd_wdata   in   DATA_WIDTH  write data
//  rsp_valid   out  1           response held until rsp_ready
//  rsp_ready   in   1           response consumer ready
//  rsp_rdata   out  DATA_WIDTH  read data (0 for writes / errors)
//  rsp_err     out  1           PSLVERR seen, or timeout
//  PADDR       out  ADDR_WIDTH  APB address
//  PWRITE      out  1           APB direction
//  PSEL        out  1           APB select
//  PENABLE     out  1           APB enable
//  PWDATA      out  DATA_WIDTH  APB write data
//  PRDATA      in   DATA_WIDTH  APB read data
//  PREADY      in   1           APB ready
//  PSLVERR     in   1           APB error, valid only with PREADY in ACCESS
// BEHAVIOUR
//  - Reset (async, PRESETn=0): state IDLE; PSEL, PENABLE, PWRITE, rsp_valid, rsp_err = 0; PADDR, PWDATA, rsp_rdata = 0;
//    cmd_ready = 0 while in reset. Reset mid-transfer aborts the transfer at once; the in-flight response is dropped.
//  - FSM: IDLE -> SETUP -> ACCESS -> IDLE. All APB outputs registered.
//  - IDLE: cmd_ready = !rsp_valid | rsp_ready. Accept at edge N: latch addr/write/wdata into PADDR/PWRITE/PWDATA,
//    PSEL=1, PENABLE=0 from N+1 (SETUP).
//  - SETUP: one cycle only; next edge PENABLE=1 (ACCESS). PADDR/PWRITE/PWDATA/PSEL stable SETUP through ACCESS end.
//  - ACCESS: each edge with PREADY=0 holds all outputs (wait state). Edge with PREADY=1 completes the transfer:
//    PSEL=PENABLE=0, rsp_valid=1, rsp_err=PSLVERR, rsp_rdata = (!PWRITE & !PSLVERR) ? PRDATA : 0.
//  - Zero-wait latency: accept edge N -> rsp_valid visible after edge N+3. Every extra wait cycle adds 1.
//  - Response: one-entry register. Cleared on rsp_valid & rsp_ready unless a new completion loads it on the same edge.
//    No new command is accepted while an unconsumed response is pending, so a completion never overwrites one.
//  - Back-to-back: cmd accepted on the completion+1 edge when rsp_ready=1; PSEL drops for at least the IDLE cycle.
//  - PSLVERR, PRDATA are ignored outside ACCESS with PREADY=1.
// CONFIGURATION
//  APB_MASTER_TIMEOUT_EN defined: wait counter (width clog2(TIMEOUT_CYCLES+1)) clears on entering ACCESS and
//    increments per PREADY=0 edge. At count == TIMEOUT_CYCLES with PREADY still 0: abort, PSEL=PENABLE=0,
//    rsp_valid=1, rsp_err=1, rsp_rdata=0. PREADY=1 on the same edge wins (normal completion).
//  Undefined: no counter; ACCESS waits for PREADY indefinitely.
// STRUCTURE
//  Package apb_pkg: state enum {IDLE,SETUP,ACCESS}; SPI register address constants
//    CR1=3'd0, CR2=3'd1, BR=3'd2, SR=3'd3, DR=3'd5.
//  Sub-module apb_wait_timer (timeout counter; instantiated only under APB_MASTER_TIMEOUT_EN).
// TESTING
//  1. Write CR1=8'h50, PREADY tied 1 -> PSEL high 2 cycles, PENABLE in the 2nd, PADDR=0, PWDATA=8'h50;
//     rsp_valid 3 cycles after accept, rsp_err=0, rsp_rdata=0.
//  2. Read DR, slave holds PREADY=0 for 2 cycles then PRDATA=8'hA5 -> ACCESS lasts 3 cycles; rsp_rdata=8'hA5,
//     latency 5.
//  3. Read SR, PSLVERR=1 with PREADY=1 -> rsp_err=1, rsp_rdata=0; next command proceeds normally.
//  4. rsp_ready=0 for 4 cycles after completion with cmd_valid held -> cmd_ready=0, rsp stable; command accepted
//     on the edge rsp_ready rises.
//  5. APB_MASTER_TIMEOUT_EN, PREADY stuck 0 -> abort after 16 wait cycles, rsp_err=1; undefined: PSEL held 40+ cycles.
//  6. PRESETn low mid-ACCESS -> PSEL/PENABLE/rsp_valid 0 immediately; after release, write BR=8'h0A completes
//     normally.

Source files
------------

// File: rtl/apb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : apb_pkg
// Description : Shared definitions for the APB requester bridge: transfer
//               phase encoding, SPI controller register map and a small
//               helper deciding when read data is returned.
// Revision    : 1.0 - initial release
// ============================================================================
package apb_pkg;

  // APB transfer phase currently presented on the bus.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  // SPI controller register map (APB address space).
  localparam logic [2:0] CR1 = 3'd0;
  localparam logic [2:0] CR2 = 3'd1;
  localparam logic [2:0] BR  = 3'd2;
  localparam logic [2:0] SR  = 3'd3;
  localparam logic [2:0] DR  = 3'd5;

  // Only a read that finished without a slave error carries data back;
  // writes and failed transfers report zero.
  function automatic logic returns_rdata(input logic write, input logic slverr);
    return !write && !slverr;
  endfunction

endpackage
`default_nettype wire

// File: rtl/apb_wait_timer.sv
`default_nettype none
// ============================================================================
// Module      : apb_wait_timer
// Description : Counts APB ACCESS wait states and flags when the allowed
//               number has been used up. Only built when
//               APB_MASTER_TIMEOUT_EN is defined.
// Ports       : clk      - clock, rising edge
//               rst_n    - asynchronous active-low reset
//               clear    - restart the count (asserted in the SETUP phase)
//               count_en - one wait state observed on this edge
//               expired  - TIMEOUT_CYCLES wait states have elapsed
// Revision    : 1.0 - initial release
// ============================================================================
module apb_wait_timer #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] count;

  // The count saturates at the limit so it can never wrap back to a
  // value that would hide an expired transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (count_en && (count != LIMIT)) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == LIMIT);

endmodule
`default_nettype wire

// File: rtl/apb_master_bridge.sv
`default_nettype none
// ============================================================================
// Module      : apb_master_bridge
// Description : APB requester for the SPI controller register block.
//               Accepts single-beat commands over valid/ready, runs one APB
//               SETUP/ACCESS transfer per command, honours PREADY wait
//               states and returns read data plus an error flag as a single
//               held response.
// Config      : APB_MASTER_TIMEOUT_EN - when defined, an ACCESS phase that
//               sees TIMEOUT_CYCLES wait states is aborted with rsp_err=1.
//               When undefined the bridge waits for PREADY indefinitely.
// Ports       : PCLK, PRESETn            - clock, async active-low reset
//               cmd_valid/ready/write/addr/wdata - command channel
//               rsp_valid/ready/rdata/err         - response channel
//               PADDR/PWRITE/PSEL/PENABLE/PWDATA  - APB requester outputs
//               PRDATA/PREADY/PSLVERR             - APB completer inputs
// Revision    : 1.0 - initial release
// ============================================================================
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 8
`ifdef APB_MASTER_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 16
`endif
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  // command channel
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  // response channel
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  // APB requester
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic                  PWRITE,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  apb_state_e state;

  // Set for the one cycle between accepting a command and raising PSEL.
  // The address/data are already on the bus then, so the SETUP phase that
  // follows presents values that have been stable for a full cycle.
  logic launch;

  logic cmd_fire;
  logic wait_expired;

  // A new command is only taken when the response register is free (or is
  // being drained on this very edge), so a completion never overwrites an
  // unconsumed response.
  assign cmd_ready = PRESETn && (state == IDLE) && !launch &&
                     (!rsp_valid || rsp_ready);
  assign cmd_fire  = cmd_valid && cmd_ready;

`ifdef APB_MASTER_TIMEOUT_EN
  logic timer_clear;
  logic timer_count;

  assign timer_clear = (state == SETUP);
  assign timer_count = (state == ACCESS) && !PREADY;

  apb_wait_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk      (PCLK),
    .rst_n    (PRESETn),
    .clear    (timer_clear),
    .count_en (timer_count),
    .expired  (wait_expired)
  );
`else
  assign wait_expired = 1'b0;
`endif

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state     <= IDLE;
      launch    <= 1'b0;
      PADDR     <= '0;
      PWRITE    <= 1'b0;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      PWDATA    <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      // Drain the response register; a completion further down on the same
      // edge takes priority because its assignments come later.
      if (rsp_valid && rsp_ready) begin
        rsp_valid <= 1'b0;
        rsp_err   <= 1'b0;
        rsp_rdata <= '0;
      end

      case (state)
        IDLE: begin
          if (launch) begin
            PSEL    <= 1'b1;
            PENABLE <= 1'b0;
            launch  <= 1'b0;
            state   <= SETUP;
          end else if (cmd_fire) begin
            PADDR  <= cmd_addr;
            PWRITE <= cmd_write;
            PWDATA <= cmd_wdata;
            launch <= 1'b1;
          end
        end

        SETUP: begin
          PENABLE <= 1'b1;
          state   <= ACCESS;
        end

        ACCESS: begin
          // PREADY is checked first so a completion on the timeout edge is
          // reported as a normal transfer.
          if (PREADY) begin
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= PSLVERR;
            rsp_rdata <= returns_rdata(PWRITE, PSLVERR) ? PRDATA : '0;
            state     <= IDLE;
          end else if (wait_expired) begin
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
            state     <= IDLE;
          end
        end

        default: begin
          PSEL    <= 1'b0;
          PENABLE <= 1'b0;
          launch  <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_apb_master_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb_master_bridge
// Description : Self-checking bench for apb_master_bridge. A behavioural APB
//               completer with programmable wait states and error response
//               sits on the bus; a register-map reference model predicts
//               every response. Directed cases cover the register scenarios,
//               back-pressure, stuck slave and reset; a randomized loop
//               covers mixed traffic. Builds with or without
//               APB_MASTER_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_master_bridge;
  import apb_pkg::*;

  localparam int AW = 3;
  localparam int DW = 8;

  logic          PCLK = 1'b0;
  logic          PRESETn = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic [AW-1:0] PADDR;
  logic          PWRITE;
  logic          PSEL;
  logic          PENABLE;
  logic [DW-1:0] PWDATA;
  logic [DW-1:0] PRDATA;
  logic          PREADY;
  logic          PSLVERR;

  int total = 0;
  int bad   = 0;

  // completer behaviour for the transfer in flight
  int   plan_wait = 0;
  logic plan_err  = 1'b0;
  int   acc_cnt   = 0;

  logic [DW-1:0] slave_mem [8];   // completer's register contents
  logic [DW-1:0] ref_mem   [8];   // reference model of the same registers

  apb_master_bridge #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW)
  ) dut (
    .PCLK      (PCLK),
    .PRESETn   (PRESETn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .PADDR     (PADDR),
    .PWRITE    (PWRITE),
    .PSEL      (PSEL),
    .PENABLE   (PENABLE),
    .PWDATA    (PWDATA),
    .PRDATA    (PRDATA),
    .PREADY    (PREADY),
    .PSLVERR   (PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // APB completer: decides PREADY/PSLVERR/PRDATA mid-cycle. Outside a
  // completing ACCESS cycle it drives noise that the bridge must ignore.
  initial begin
    PREADY  = 1'b0;
    PSLVERR = 1'b0;
    PRDATA  = '0;
    for (int i = 0; i < 8; i++) begin
      slave_mem[i] = 8'hA0 + 8'(i);
    end
    forever begin
      @(negedge PCLK);
      if (PSEL && PENABLE) begin
        if (acc_cnt >= plan_wait) begin
          PREADY  = 1'b1;
          PSLVERR = plan_err;
          PRDATA  = plan_err ? 8'($urandom) : slave_mem[PADDR];
          if (PWRITE && !plan_err) slave_mem[PADDR] = PWDATA;
        end else begin
          PREADY  = 1'b0;
          PSLVERR = 1'($urandom);
          PRDATA  = 8'($urandom);
        end
        acc_cnt++;
      end else begin
        acc_cnt = 0;
        PREADY  = 1'($urandom);
        PSLVERR = 1'($urandom);
        PRDATA  = 8'($urandom);
      end
    end
  end

  // One complete command: accept, bus-phase check, latency, response value,
  // optional response back-pressure for 'hold' cycles, then drain.
  task automatic run_cmd(input logic wr, input logic [2:0] addr, input logic [7:0] wdata,
                         input int waits, input logic err, input int hold);
    int            k;
    int            j;
    int            psel_n;
    int            pen_n;
    int            bus_bad;
    int            stall_bad;
    logic          seen;
    logic [7:0]    exp_rdata;
    logic [7:0]    cap_rdata;
    logic          cap_err;

    exp_rdata = (wr || err) ? 8'h00 : ref_mem[addr];
    if (wr && !err) ref_mem[addr] = wdata;
    plan_wait = waits;
    plan_err  = err;

    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    cmd_valid = 1'b1;
    k = 0;
    while (!cmd_ready && k < 20) begin
      @(negedge PCLK); #1;
      k++;
    end
    check_eq("accept", 32'(k < 20), 1);
    if (k >= 20) begin
      cmd_valid = 1'b0;
      return;
    end
    @(posedge PCLK); #1;           // accept edge N
    cmd_valid = 1'b0;
    cmd_wdata = 8'($urandom);
    cmd_addr  = 3'($urandom);
    if (hold > 0) rsp_ready = 1'b0;

    j = 0; seen = 1'b0; psel_n = 0; pen_n = 0; bus_bad = 0;
    while (j <= waits + 8) begin
      @(negedge PCLK); #1;         // state after edge N+j
      if (rsp_valid) begin
        seen = 1'b1;
        break;
      end
      if (PSEL) begin
        psel_n++;
        if (PADDR != addr || PWRITE != wr || (wr && PWDATA != wdata)) bus_bad++;
      end
      if (PENABLE) begin
        pen_n++;
        if (!PSEL) bus_bad++;
      end
      j++;
    end
    check_eq("rsp_seen", 32'(seen), 1);
    check_eq("latency", j, 3 + waits);
    check_eq("psel_cycles", psel_n, 2 + waits);
    check_eq("penable_cycles", pen_n, 1 + waits);
    check_eq("bus_stable", bus_bad, 0);
    check_eq("rsp_err", 32'(rsp_err), 32'(err));
    check_eq("rsp_rdata", 32'(rsp_rdata), 32'(exp_rdata));

    if (hold > 0) begin
      cap_rdata = rsp_rdata;
      cap_err   = rsp_err;
      stall_bad = 0;
      repeat (hold) begin
        @(negedge PCLK); #1;
        if (!rsp_valid || rsp_rdata != cap_rdata || rsp_err != cap_err || PSEL) stall_bad++;
      end
      check_eq("rsp_hold", stall_bad, 0);
      rsp_ready = 1'b1;
    end
    @(posedge PCLK); #1;
    check_eq("rsp_drained", 32'(rsp_valid), 0);
  endtask

  initial begin
    int   j;
    int   psel_n;
    int   busy_bad;
    int   stall_bad;
    logic seen;

    for (int i = 0; i < 8; i++) begin
      ref_mem[i] = 8'hA0 + 8'(i);
    end

    // ---------------- reset state ----------------
    #1;
    check_eq("reset_psel", 32'(PSEL), 0);
    check_eq("reset_penable", 32'(PENABLE), 0);
    check_eq("reset_rsp_valid", 32'(rsp_valid), 0);
    check_eq("reset_cmd_ready", 32'(cmd_ready), 0);
    check_eq("reset_paddr", 32'(PADDR), 0);
    check_eq("reset_pwdata", 32'(PWDATA), 0);
    repeat (2) @(negedge PCLK);
    #1 PRESETn = 1'b1;
    #1;
    check_eq("idle_cmd_ready", 32'(cmd_ready), 1);

    // ---------------- register scenarios ----------------
    run_cmd(1'b1, CR1, 8'h50, 0, 1'b0, 0);   // zero-wait write
    run_cmd(1'b0, DR,  8'h00, 2, 1'b0, 0);   // two wait states, reads A5
    run_cmd(1'b0, SR,  8'h00, 0, 1'b1, 0);   // slave error
    run_cmd(1'b0, CR1, 8'h00, 1, 1'b0, 0);   // normal after error, reads 50

    // ---------------- response back-pressure ----------------
    rsp_ready = 1'b0;
    plan_wait = 0;
    plan_err  = 1'b0;
    cmd_write = 1'b1;
    cmd_addr  = CR2;
    cmd_wdata = 8'h3C;
    cmd_valid = 1'b1;
    check_eq("bp_ready_idle", 32'(cmd_ready), 1);
    @(posedge PCLK); #1;
    ref_mem[CR2] = 8'h3C;
    cmd_write = 1'b0;                        // next command waits: read CR2
    busy_bad = 0;
    j = 0;
    while (j < 10) begin
      @(negedge PCLK); #1;
      if (rsp_valid) break;
      if (cmd_ready) busy_bad++;
      j++;
    end
    check_eq("bp_latency", j, 3);
    check_eq("bp_busy_ready", busy_bad, 0);
    check_eq("bp_wr_rdata", 32'(rsp_rdata), 0);
    stall_bad = 0;
    repeat (3) begin
      @(negedge PCLK); #1;
      if (!rsp_valid || rsp_err || rsp_rdata != 8'h00 || cmd_ready || PSEL) stall_bad++;
    end
    check_eq("bp_stall", stall_bad, 0);
    rsp_ready = 1'b1;
    #1;
    check_eq("bp_ready_rise", 32'(cmd_ready), 1);
    @(posedge PCLK); #1;                     // response drained, read accepted
    cmd_valid = 1'b0;
    check_eq("bp_drained", 32'(rsp_valid), 0);
    j = 0;
    while (j < 10) begin
      @(negedge PCLK); #1;
      if (rsp_valid) break;
      j++;
    end
    check_eq("bp_rd_latency", j, 3);
    check_eq("bp_rd_rdata", 32'(rsp_rdata), 32'(ref_mem[CR2]));
    @(posedge PCLK); #1;

    // ---------------- randomized traffic ----------------
    for (int n = 0; n < 30; n++) begin
      logic wr;
      logic er;
      wr = 1'($urandom_range(0, 1));
      er = ($urandom_range(0, 5) == 0);
      run_cmd(wr, 3'($urandom_range(0, 7)), 8'($urandom), $urandom_range(0, 4), er,
              $urandom_range(0, 2));
      repeat ($urandom_range(0, 2)) @(negedge PCLK);
      #1;
    end

    // ---------------- stuck completer ----------------
    plan_wait = 1000;
    plan_err  = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = BR;
    cmd_valid = 1'b1;
    check_eq("stuck_ready", 32'(cmd_ready), 1);
    @(posedge PCLK); #1;
    cmd_valid = 1'b0;
    j = 0; seen = 1'b0; psel_n = 0;
    while (j < 60) begin
      @(negedge PCLK); #1;
      if (rsp_valid) begin
        seen = 1'b1;
        break;
      end
      if (PSEL) psel_n++;
      j++;
    end
`ifdef APB_MASTER_TIMEOUT_EN
    check_eq("timeout_seen", 32'(seen), 1);
    check_eq("timeout_latency", j, 3 + 16);
    check_eq("timeout_psel", psel_n, 18);
    check_eq("timeout_err", 32'(rsp_err), 1);
    check_eq("timeout_rdata", 32'(rsp_rdata), 0);
    @(posedge PCLK); #1;
    cmd_valid = 1'b1;                        // another stuck read to reset mid-ACCESS
    @(posedge PCLK); #1;
    cmd_valid = 1'b0;
    repeat (6) @(negedge PCLK);
    #1;
`else
    check_eq("stuck_no_rsp", 32'(seen), 0);
    check_eq("stuck_psel", psel_n, 59);
`endif

    // ---------------- reset in the middle of ACCESS ----------------
    check_eq("pre_reset_access", 32'(PSEL && PENABLE), 1);
    PRESETn = 1'b0;
    #1;
    check_eq("mid_reset_psel", 32'(PSEL), 0);
    check_eq("mid_reset_penable", 32'(PENABLE), 0);
    check_eq("mid_reset_rsp_valid", 32'(rsp_valid), 0);
    check_eq("mid_reset_cmd_ready", 32'(cmd_ready), 0);
    @(negedge PCLK);
    @(negedge PCLK); #1;
    PRESETn = 1'b1;
    #1;
    run_cmd(1'b1, BR, 8'h0A, 0, 1'b0, 0);
    run_cmd(1'b0, BR, 8'h00, 1, 1'b0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
`default_nettype wire
